wb_traffic_master: RTL and testbench
====================================

# wb_traffic_master

Synthesizable Wishbone master that generates pseudo-random single and 4-beat incrementing-burst read/write traffic for bus-fabric (conbus) verification and on-chip bring-up. It sits directly upstream of the bus slaves, on one conbus master port, and drives the cycles they acknowledge. It accumulates a checksum of read data and beat counts so a bench or CSR block can check the run. An optional watchdog aborts cycles that a slave never acknowledges.

## Interface
- `id`, default 0: 8-bit master identifier embedded in write data.
- `seed`, default 32'h1: LFSR reset value; must be nonzero.
- `ntrans`, default 16: transactions per run, 1..65535.
- `adr_mask`, default 32'h0000fff0: AND mask applied to the LFSR to form addresses.
- `timeout`, default 255: watchdog limit in cycles; only used when the watchdog is compiled in.
- `sys_clk`  in  1: clock; all logic on the rising edge.
- `sys_rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: pulse that begins a run; ignored while busy.
- `busy`  out  1: run in progress.
- `done`  out  1: sticky; set at run end, cleared by the next accepted start.
- `error`  out  1: sticky watchdog abort flag; cleared by accepted start.
- `checksum`  out  32: XOR of all read data in the run.
- `rcount`, `wcount`  out  16 each: acknowledged read / write beats.
- `dat_w`  out  32: Wishbone write data.
- `dat_r`  in  32: Wishbone read data.
- `adr`  out  32: Wishbone address.
- `cti`  out  3: Wishbone cycle type.
- `we`  out  1: Wishbone write enable.
- `sel`  out  4: Wishbone byte select.
- `cyc`  out  1: Wishbone cycle.
- `stb`  out  1: Wishbone strobe.
- `ack`  in  1: Wishbone acknowledge.

## Operation
- All outputs are registered. Reset (`sys_rst_n`=0 at an edge) clears every output to 0 and sets the LFSR to `seed`. Reset mid-cycle drops `cyc`/`stb` at that edge.
- LFSR (32-bit Fibonacci): `lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}`. It steps exactly once per transaction, at the edge that launches it.
- Each transaction launch decodes fields from the pre-step LFSR value:
  - `we` = `lfsr[0]`; burst = `lfsr[1]`.
  - Single: `sel` = `lfsr[5:2]`, with 4'h0 replaced by 4'hf; `adr` = `lfsr & adr_mask` with `[1:0]` forced to 0; `cti` = 3'b000.
  - Burst: `sel` = 4'hf; `adr` = `lfsr & adr_mask` with `[3:0]` forced to 0; 4 beats; `cti` = 3'b010 on beats 0-2 and 3'b111 on beat 3.
- Write data per beat: `{id[7:0], txn_idx[7:0], adr[15:0]}`, recomputed whenever `adr` changes.
- FSM states:
  - IDLE → ISSUE on `start`.
  - ISSUE: `cyc`=`stb`=1. On `ack`: beat done; burst not finished → stay in ISSUE with `adr`+=4; last beat → GAP.
  - GAP: one cycle with `cyc`=`stb`=0. Then ISSUE if `txn_idx` < `ntrans`, else DONE.
  - DONE: asserts `done`, deasserts `busy`, goes to IDLE.
- On each read ack: `checksum` ^= `dat_r`, `rcount`++. On each write ack: `wcount`++. Counters saturate at 16'hffff.
- An accepted start clears `checksum`, `rcount`, `wcount`, `done`, `error`, and `txn_idx`. The LFSR is not reseeded; it continues across runs.
- `ack` while not in ISSUE is ignored.

## Timing
- `start` sampled at edge k → `busy`, `cyc`, `stb` high after edge k.
- Last ack of a transaction sampled at edge m → `cyc`/`stb` low after m. The next transaction's `cyc` rises after edge m+1.
- Burst beats may be acknowledged back-to-back (a new beat every cycle).
- Final ack of the run at edge m → `done`=1 and `busy`=0 after edge m+2 (GAP, then DONE).
- `start` arriving in the same cycle as DONE is ignored.

## Configuration
- `WBTG_TIMEOUT_EN` defined: a counter runs in ISSUE and clears on each ack. When it reaches `timeout`, the block drops `cyc`/`stb`, sets `error`, skips to DONE, and abandons the remaining transactions.
- `WBTG_TIMEOUT_EN` undefined: no counter. The master waits forever for `ack`, and `error` is constant 0.

## Test plan
- Reset with `sys_rst_n`=0 held for 3 cycles → all outputs 0; after release, `busy`=0 and `cyc`=0.
- `seed`=1, `ntrans`=1, slave acks the first cycle after `stb`:
  - LFSR bits[1:0]=01 → single write, `adr`=0, `sel`=4'hf, `cti`=000.
  - `wcount`=1; `done` is high 2 cycles after the ack.
- Forced burst read (pick `seed` with bits[1:0]=10), slave returns 1, 2, 3, 4 back-to-back:
  - `adr` steps +4 per beat; `cti` = 010, 010, 010, 111.
  - `checksum`=32'h4, `rcount`=4.
- `ntrans`=16 against a slave that randomly delays `ack`:
  - Transactions are separated by exactly one idle-`cyc` cycle.
  - `rcount`+`wcount` equals the sum of decoded beats.
- With `WBTG_TIMEOUT_EN` and `timeout`=8, the slave never acks → `cyc` drops 8 cycles after launch; `error`=1, `done`=1.
- Pulse `start` while busy and pulse `sys_rst_n` mid-burst:
  - The mid-run start is ignored.
  - Reset drops `cyc` at the next edge and zeroes the counters.

Source files
------------

// File: rtl/wb_traffic_master.sv
// wb_traffic_master: pseudo-random Wishbone single/4-beat burst traffic generator; define WBTG_TIMEOUT_EN to add the ack watchdog
module wb_traffic_master #(
  parameter logic [7:0]  id       = 8'h00,
  parameter logic [31:0] seed     = 32'h1,
  parameter logic [15:0] ntrans   = 16'd16,
  parameter logic [31:0] adr_mask = 32'h0000fff0,
  parameter logic [31:0] timeout  = 32'd255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum,
  output logic [15:0] rcount,
  output logic [15:0] wcount,
  output logic [31:0] dat_w,
  input  logic [31:0] dat_r,
  output logic [31:0] adr,
  output logic [2:0]  cti,
  output logic        we,
  output logic [3:0]  sel,
  output logic        cyc,
  output logic        stb,
  input  logic        ack
);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d, adr_q, adr_d, dat_w_q, dat_w_d, checksum_q, checksum_d;
  logic [15:0] txn_idx_q, txn_idx_d, rcount_q, rcount_d, wcount_q, wcount_d;
  logic [2:0] cti_q, cti_d;
  logic [3:0] sel_q, sel_d;
  logic [1:0] beat_q, beat_d;
  logic burst_q, burst_d, we_q, we_d, cyc_q, cyc_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic accept, launch, beat_ack, last, advance, abort;
  assign accept   = state_q == IDLE && start;
  assign launch   = accept || (state_q == GAP && txn_idx_q < ntrans);
  assign beat_ack = state_q == ISSUE && ack;
  assign last     = beat_ack && (!burst_q || beat_q == 2'd3);
  assign advance  = beat_ack && !last;
`ifdef WBTG_TIMEOUT_EN
  logic [31:0] to_q, to_d;
  assign abort = state_q == ISSUE && !ack && to_q == timeout - 32'd1;
  // watchdog counts unacknowledged cycles in ISSUE, restarting on every ack
  always_comb to_d = (state_q == ISSUE && !ack) ? to_q + 32'd1 : 32'd0;
  // watchdog counter register
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) to_q <= '0;
    else to_q <= to_d;
`else
  assign abort = 1'b0 && timeout != 32'd0;
`endif
  // next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ISSUE : IDLE;
      ISSUE:   state_d = abort ? DONE : last ? GAP : ISSUE;
      GAP:     state_d = txn_idx_q < ntrans ? ISSUE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // transaction decode from the pre-step LFSR, beat sequencing and run statistics
  always_comb begin
    lfsr_d     = launch ? {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]} : lfsr_q;
    txn_idx_d  = accept ? 16'd0 : last ? txn_idx_q + 16'd1 : txn_idx_q;
    burst_d    = launch ? lfsr_q[1] : burst_q;
    we_d       = launch ? lfsr_q[0] : we_q;
    beat_d     = launch ? 2'd0 : beat_ack ? beat_q + 2'd1 : beat_q;
    adr_d      = launch ? lfsr_q & adr_mask & (lfsr_q[1] ? 32'hffff_fff0 : 32'hffff_fffc)
               : advance ? adr_q + 32'd4 : adr_q;
    sel_d      = launch ? ((lfsr_q[1] || lfsr_q[5:2] == 4'h0) ? 4'hf : lfsr_q[5:2]) : sel_q;
    cti_d      = launch ? (lfsr_q[1] ? 3'b010 : 3'b000) : (advance && beat_q == 2'd2) ? 3'b111 : cti_q;
    dat_w_d    = (launch || advance) ? {id, txn_idx_d[7:0], adr_d[15:0]} : dat_w_q;
    cyc_d      = state_d == ISSUE;
    busy_d     = accept ? 1'b1 : state_q == DONE ? 1'b0 : busy_q;
    done_d     = accept ? 1'b0 : state_q == DONE ? 1'b1 : done_q;
    error_d    = accept ? 1'b0 : abort ? 1'b1 : error_q;
    checksum_d = accept ? 32'd0 : (beat_ack && !we_q) ? checksum_q ^ dat_r : checksum_q;
    rcount_d   = accept ? 16'd0 : (beat_ack && !we_q) ? rcount_q + {15'd0, rcount_q != 16'hffff} : rcount_q;
    wcount_d   = accept ? 16'd0 : (beat_ack && we_q) ? wcount_q + {15'd0, wcount_q != 16'hffff} : wcount_q;
  end
  // state and output registers
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= seed;
      txn_idx_q  <= '0;
      burst_q    <= 1'b0;
      we_q       <= 1'b0;
      beat_q     <= '0;
      adr_q      <= '0;
      sel_q      <= '0;
      cti_q      <= '0;
      dat_w_q    <= '0;
      cyc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      checksum_q <= '0;
      rcount_q   <= '0;
      wcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      txn_idx_q  <= txn_idx_d;
      burst_q    <= burst_d;
      we_q       <= we_d;
      beat_q     <= beat_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      cti_q      <= cti_d;
      dat_w_q    <= dat_w_d;
      cyc_q      <= cyc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      checksum_q <= checksum_d;
      rcount_q   <= rcount_d;
      wcount_q   <= wcount_d;
    end
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign checksum = checksum_q;
  assign rcount   = rcount_q;
  assign wcount   = wcount_q;
  assign dat_w    = dat_w_q;
  assign adr      = adr_q;
  assign cti      = cti_q;
  assign we       = we_q;
  assign sel      = sel_q;
  assign cyc      = cyc_q;
  assign stb      = cyc_q;
endmodule

// File: tb/tb_wb_traffic_master.sv
// tb_wb_traffic_master: scoreboard bench with a Wishbone slave responder for wb_traffic_master
module tb_wb_traffic_master;
  localparam logic [7:0]  ID     = 8'h5a;
  localparam logic [31:0] SEED   = 32'h1;
  localparam int          NTRANS = 4;
  localparam logic [31:0] MASK   = 32'h0000fff0;
  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [31:0] dat;
  } beat_t;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, start = 1'b0, ack = 1'b0;
  logic [31:0] dat_r = '0;
  logic busy, done, error, we, cyc, stb;
  logic [31:0] checksum, dat_w, adr;
  logic [15:0] rcount, wcount;
  logic [2:0] cti;
  logic [3:0] sel;
  beat_t q[$];
  logic [31:0] m_lfsr, exp_ck;
  int exp_r, exp_w;
  int ncmp = 0, nerr = 0;
  wb_traffic_master #(.id(ID), .seed(SEED), .ntrans(16'(NTRANS)), .adr_mask(MASK), .timeout(32'd8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .checksum(checksum), .rcount(rcount), .wcount(wcount), .dat_w(dat_w), .dat_r(dat_r), .adr(adr),
    .cti(cti), .we(we), .sel(sel), .cyc(cyc), .stb(stb), .ack(ack)
  );
  initial forever #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // expected beats of one whole run, derived from the bench's own LFSR copy
  task automatic push_run();
    for (int t = 0; t < NTRANS; t++) begin
      logic b;
      logic [31:0] base;
      beat_t e;
      b = m_lfsr[1];
      base = m_lfsr & MASK;
      base[1:0] = 2'b00;
      if (b) base[3:0] = 4'h0;
      for (int k = 0; k < (b ? 4 : 1); k++) begin
        e.adr = base + 32'(4 * k);
        e.we  = m_lfsr[0];
        e.sel = b ? 4'hf : (m_lfsr[5:2] == 4'h0 ? 4'hf : m_lfsr[5:2]);
        e.cti = b ? (k == 3 ? 3'b111 : 3'b010) : 3'b000;
        e.dat = {ID, 8'(t), e.adr[15:0]};
        q.push_back(e);
      end
      m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
    end
  endtask
  task automatic start_run();
    push_run();
    exp_ck = '0;
    exp_r = 0;
    exp_w = 0;
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("cyc_after_start", 32'(cyc), 1);
    chk("stb_after_start", 32'(stb), 1);
  endtask
  // slave responder: acks after 0..max_dly cycles, compares each acked beat with the scoreboard
  task automatic serve(input int max_dly, input bit rnd, input int start_at, input bit dstart, input int stop);
    int n = 0, dly = 0, idle = 0, nack = 0, last = -100, rdn = 0;
    bit seen = 0, prev = 0;
    beat_t e;
    while (!done && n < 2000 && !(stop != 0 && nack == stop)) begin
      ack = 1'b0;
      start = (n == start_at) || (dstart && q.size() == 0 && n == last + 2);
      if (cyc) begin
        if (seen && !prev) chk("idle_cycles_between_txns", 32'(idle), 1);
        seen = 1;
        idle = 0;
        if (dly != 0) dly--;
        else begin
          if (q.size() != 0) e = q.pop_front();
          else e = 'x;
          chk("adr", adr, e.adr);
          chk("we", 32'(we), 32'(e.we));
          chk("sel", 32'(sel), 32'(e.sel));
          chk("cti", 32'(cti), 32'(e.cti));
          chk("dat_w", dat_w, e.dat);
          chk("stb", 32'(stb), 1);
          ack = 1'b1;
          if (e.we === 1'b0) begin
            rdn++;
            dat_r = rnd ? $urandom : 32'(rdn);
            exp_ck ^= dat_r;
            exp_r++;
          end else exp_w++;
          nack++;
          last = n;
          dly = max_dly != 0 ? int'($urandom_range(max_dly)) : 0;
        end
      end else idle++;
      prev = cyc;
      @(negedge sys_clk);
      n++;
    end
    ack = 1'b0;
    start = 1'b0;
    if (stop == 0) begin
      chk("done_latency_from_last_ack", 32'(n - last), 3);
      chk("done", 32'(done), 1);
      chk("busy_at_end", 32'(busy), 0);
      chk("cyc_at_end", 32'(cyc), 0);
      chk("rcount", 32'(rcount), 32'(exp_r));
      chk("wcount", 32'(wcount), 32'(exp_w));
      chk("checksum", checksum, exp_ck);
      chk("error", 32'(error), 0);
      chk("leftover_beats", 32'(q.size()), 0);
    end
  endtask
  initial begin
    int hi, k;
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_rcount", 32'(rcount), 0);
    chk("rst_wcount", 32'(wcount), 0);
    chk("rst_dat_w", dat_w, 0);
    chk("rst_adr", adr, 0);
    chk("rst_cti", 32'(cti), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_stb", 32'(stb), 0);
    m_lfsr = SEED;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_cyc", 32'(cyc), 0);
    // seed 1: single write, burst write, burst read (data 1..4), single write; immediate acks
    start_run();
    serve(0, 0, -1, 0, 0);
    chk("burst_read_checksum", checksum, 32'h4);
    chk("burst_read_rcount", 32'(rcount), 4);
    // random ack delays and data, start pulsed mid-run and again while in DONE
    start_run();
    serve(3, 1, 5, 1, 0);
    @(negedge sys_clk);
    chk("start_in_done_ignored_busy", 32'(busy), 0);
    chk("start_in_done_ignored_cyc", 32'(cyc), 0);
    start_run();
    serve(2, 1, -1, 0, 0);
    // reset mid-burst: restart from seed, stop after single + two burst beats
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    q.delete();
    m_lfsr = SEED;
    start_run();
    serve(0, 0, -1, 0, 3);
    chk("mid_burst_cyc", 32'(cyc), 1);
    chk("mid_burst_adr", adr, 32'h8);
    chk("mid_burst_wcount", 32'(wcount), 3);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    chk("rst_mid_cyc", 32'(cyc), 0);
    chk("rst_mid_stb", 32'(stb), 0);
    chk("rst_mid_wcount", 32'(wcount), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    q.delete();
    m_lfsr = SEED;
    start_run();
    serve(1, 0, -1, 0, 0);
    chk("reseeded_checksum", checksum, 32'h4);
`ifdef WBTG_TIMEOUT_EN
    hi = 0;
    k = 0;
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    while (cyc && hi < 50) begin
      hi++;
      @(negedge sys_clk);
    end
    chk("timeout_cyc_cycles", 32'(hi), 8);
    while (!done && k < 50) begin
      k++;
      @(negedge sys_clk);
    end
    chk("timeout_error", 32'(error), 1);
    chk("timeout_done", 32'(done), 1);
    chk("timeout_busy", 32'(busy), 0);
`else
    hi = 0;
    k = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
